// File: rtl/inv_key_scheduler_if.sv
// Load and round-key streaming bundle of the AES-128 inverse key scheduler.
// The master side loads keys and consumes round keys; the slave side is the scheduler.
interface inv_key_scheduler_if;
   logic         start;
   logic         key_is_last;
   logic [0:127] key;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [0:127] rk_data;
   logic [3:0]   rk_round;
   logic         rk_last;
   logic         done;

   modport master (
      output start, key_is_last, key, rk_ready,
      input  busy, rk_valid, rk_data, rk_round, rk_last, done
   );

   modport slave (
      input  start, key_is_last, key, rk_ready,
      output busy, rk_valid, rk_data, rk_round, rk_last, done
   );
endinterface

// File: rtl/inv_key_scheduler.sv
// AES-128 inverse key scheduler: streams round keys Nr..0 computed on the fly
// from either the cipher key (rolled forward first) or the final round key.
module inv_key_scheduler #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input logic                 clk,
   input logic                 rst_n,
   inv_key_scheduler_if.slave  ks
);

   if (Nk != 4 || Nr != 10) begin : g_bad_cfg
      $error("inv_key_scheduler supports only Nk=4 with Nr=10");
   end

   localparam logic [3:0] LAST_RND = 4'(Nr);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

   function automatic logic [7:0] rcon_byte(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   state_t       state;
   logic [0:127] cur_key;
   logic [3:0]   ctr;
   logic         busy_r, valid_r, last_r, done_r;
   logic [3:0]   round_r;

   logic [31:0]  w0, w1, w2, w3, rcon, sb_in, sb_rot, sb_out, t, n0, n1, n2, p0;
   logic [3:0]   rc_idx;
   logic [0:127] fwd_key, inv_key;

   // One S-box bank serves both directions: forward substitutes w3, inverse
   // substitutes the recovered previous w3 (w3^w2).
   // NOTE: every always_comb output is assigned on every pass, so no latch can be inferred.
   always_comb begin
      w0      = cur_key[0:31];
      w1      = cur_key[32:63];
      w2      = cur_key[64:95];
      w3      = cur_key[96:127];
      rc_idx  = (state == FWD) ? ctr + 4'd1 : ctr;
      rcon    = {rcon_byte(rc_idx), 24'h0};
      sb_in   = (state == FWD) ? w3 : (w3 ^ w2);
      sb_rot  = {sb_in[23:0], sb_in[31:24]};
      sb_out  = {SBOX[sb_rot[31:24]], SBOX[sb_rot[23:16]], SBOX[sb_rot[15:8]], SBOX[sb_rot[7:0]]};
      t       = sb_out ^ rcon;
      n0      = w0 ^ t;
      n1      = w1 ^ n0;
      n2      = w2 ^ n1;
      fwd_key = {n0, n1, n2, w3 ^ n2};
      p0      = w0 ^ t;
      inv_key = {p0, w1 ^ w0, w2 ^ w1, w3 ^ w2};
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         // NOTE: the key register is reset too, because rk_data must read zero after reset.
         cur_key <= '0;
         ctr     <= '0;
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         done_r  <= 1'b0;
         round_r <= '0;
      end else begin
         done_r <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ks.start) begin
                  cur_key <= ks.key;
                  busy_r  <= 1'b1;
                  if (ks.key_is_last) begin
                     ctr     <= LAST_RND;
                     state   <= REV;
                     valid_r <= 1'b1;
                     round_r <= LAST_RND;
                     last_r  <= 1'b0;
                  end else begin
                     ctr   <= '0;
                     state <= FWD;
                  end
               end
            end
            FWD: begin
               cur_key <= fwd_key;
               ctr     <= ctr + 4'd1;
               if (ctr == LAST_RND - 4'd1) begin
                  state   <= REV;
                  valid_r <= 1'b1;
                  round_r <= LAST_RND;
                  last_r  <= 1'b0;
               end
            end
            REV: begin
               if (ks.rk_ready) begin
                  if (ctr != 4'd0) begin
                     cur_key <= inv_key;
                     ctr     <= ctr - 4'd1;
                     round_r <= ctr - 4'd1;
                     last_r  <= (ctr == 4'd1);
                  end else begin
                     state   <= IDLE;
                     valid_r <= 1'b0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     round_r <= '0;
                     last_r  <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ks.busy     = busy_r;
   assign ks.rk_valid = valid_r;
   assign ks.rk_data  = cur_key;
   assign ks.rk_round = round_r;
   assign ks.rk_last  = last_r;
   assign ks.done     = done_r;

endmodule

// File: tb/tb_inv_key_scheduler.sv
// Directed bench for inv_key_scheduler: a scoreboard of known AES-128 round keys
// is filled at each start and drained as round keys are accepted.
module tb_inv_key_scheduler;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   inv_key_scheduler_if bus();

   inv_key_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ks    (bus)
   );

   typedef struct {
      logic [3:0]   round;
      logic [0:127] data;
   } exp_t;

   exp_t         sb[$];
   logic [0:127] rk_tab [11];
   int           total = 0;
   int           bad   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one start and queues the eleven round keys it must produce.
   task automatic start_op(input logic [0:127] k, input logic last);
      exp_t e;
      bus.key         = k;
      bus.key_is_last = last;
      bus.start       = 1'b1;
      step();
      bus.start = 1'b0;
      for (int r = 10; r >= 0; r--) begin
         e.round = 4'(r);
         e.data  = rk_tab[r];
         sb.push_back(e);
      end
   endtask

   // Counts edges, starting at the accepting edge, until rk_valid appears.
   task automatic wait_first(input int exp_lat, input bit pulse);
      int lat = 1;
      while (bus.rk_valid !== 1'b1 && lat < 40) begin
         check("busy_before_valid", bus.busy, 1'b1);
         if (pulse) begin
            bus.start       = lat[0];
            bus.key         = '0;
            bus.key_is_last = lat[1];
            bus.rk_ready    = 1'($urandom_range(0, 1));
         end
         step();
         lat++;
      end
      check("first_valid_latency", lat, exp_lat);
   endtask

   task automatic drain(input bit bp, input bit pulse, input int stop_round, output int cycles);
      int        cyc     = 0;
      int        stall   = 0;
      bit [15:0] stalled = '0;
      bit        rdy;
      exp_t      e;
      while (sb.size() > 0 && cyc < 400) begin
         e = sb[0];
         check("rk_valid", bus.rk_valid, 1'b1);
         check("busy", bus.busy, 1'b1);
         check("rk_round", bus.rk_round, e.round);
         check("rk_data", bus.rk_data, e.data);
         check("rk_last", bus.rk_last, e.round == 4'd0);
         if (int'(e.round) == stop_round) break;
         if (!bp) begin
            rdy = 1'b1;
         end else if (stall > 0) begin
            rdy = 1'b0;
            stall--;
         end else if ((e.round == 4'd10 || e.round == 4'd5 || e.round == 4'd0) && !stalled[e.round]) begin
            stalled[e.round] = 1'b1;
            stall = 4;
            rdy   = 1'b0;
         end else begin
            rdy = 1'($urandom_range(0, 1));
         end
         bus.rk_ready = rdy;
         if (pulse) begin
            bus.start       = cyc[0];
            bus.key         = '0;
            bus.key_is_last = cyc[1];
         end
         if (rdy) void'(sb.pop_front());
         step();
         cyc++;
      end
      bus.start    = 1'b0;
      bus.rk_ready = 1'b0;
      cycles       = cyc;
      if (stop_round < 0) check("drain_left", sb.size(), 0);
   endtask

   task automatic end_checks();
      check("done_pulse", bus.done, 1'b1);
      check("busy_end", bus.busy, 1'b0);
      check("valid_end", bus.rk_valid, 1'b0);
      check("round_end", bus.rk_round, 4'd0);
      check("last_end", bus.rk_last, 1'b0);
      check("data_hold", bus.rk_data, rk_tab[0]);
   endtask

   initial begin
      int cycles;
      rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
      rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      rst_n           = 1'b0;
      bus.start       = 1'b0;
      bus.key_is_last = 1'b0;
      bus.key         = '0;
      bus.rk_ready    = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      check("rst_busy", bus.busy, 1'b0);
      check("rst_valid", bus.rk_valid, 1'b0);
      check("rst_last", bus.rk_last, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_round", bus.rk_round, 4'd0);
      check("rst_data", bus.rk_data, 128'h0);

      // Cipher-key mode, consumer always ready.
      start_op(rk_tab[0], 1'b0);
      check("busy_after_start", bus.busy, 1'b1);
      wait_first(11, 1'b0);
      drain(1'b0, 1'b0, -1, cycles);
      check("keys_per_cycle", cycles, 11);
      end_checks();
      step();
      check("done_one_cycle", bus.done, 1'b0);

      // Last-key mode, consumer always ready.
      start_op(rk_tab[10], 1'b1);
      wait_first(1, 1'b0);
      drain(1'b0, 1'b0, -1, cycles);
      end_checks();
      step();

      // Last-key mode under backpressure with long stalls at rounds 10, 5 and 0.
      start_op(rk_tab[10], 1'b1);
      wait_first(1, 1'b0);
      drain(1'b1, 1'b0, -1, cycles);
      end_checks();

      // Back-to-back: start in the done cycle.
      start_op(rk_tab[10], 1'b1);
      check("b2b_busy", bus.busy, 1'b1);
      wait_first(1, 1'b0);
      drain(1'b0, 1'b0, -1, cycles);
      end_checks();
      step();

      // Spurious all-zero starts during FWD and REV must be ignored.
      start_op(rk_tab[0], 1'b0);
      wait_first(11, 1'b1);
      drain(1'b0, 1'b1, -1, cycles);
      end_checks();
      step();
      check("no_spurious_restart", bus.busy, 1'b0);

      // Reset while round 6 is presented, then a clean restart.
      start_op(rk_tab[10], 1'b1);
      wait_first(1, 1'b0);
      drain(1'b0, 1'b0, 6, cycles);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_valid", bus.rk_valid, 1'b0);
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_done", bus.done, 1'b0);
      check("midrst_round", bus.rk_round, 4'd0);
      sb.delete();
      step();
      check("midrst_quiet", bus.rk_valid, 1'b0);
      start_op(rk_tab[10], 1'b1);
      wait_first(1, 1'b0);
      drain(1'b0, 1'b0, -1, cycles);
      end_checks();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
